sha256_padder: RTL and testbench
================================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
- REQ-001: LEN_W, default 32, width of the message byte counter; the maximum message length is 2^LEN_W-1 bytes.
- REQ-002: clk_i  input  1  single clock; all logic on rising edge.
- REQ-003: rstn_i  input  1  reset, asynchronous and active-low.
- REQ-004: data_i  input  8  message byte.
- REQ-005: data_valid_i  input  1  data_i valid; byte accepted when data_valid_i && data_ready_o.
- REQ-006: data_last_i  input  1  qualifies the accepted byte as the final message byte.
- REQ-007: data_ready_o  output  1  padder can accept a byte this cycle.
- REQ-008: block_o  output  512  padded block for the core; byte k occupies bits [511-8k -: 8] (big-endian).
- REQ-009: block_start_o  output  1  one-cycle pulse; block_o is valid for the core (drives core start_i).
- REQ-010: first_block_o  output  1  block_o is the first block of the message; the core initialises H.
- REQ-011: last_block_o  output  1  block_o is the final block of the message.
- REQ-012: block_done_i  input  1  core finished the issued block (driven by core valid_o).
- REQ-013: msg_done_o  output  1  one-cycle pulse after the core completes the final block.

Function
- REQ-014: The SHALL implement states FILL, ISSUE, WAIT, EXTRA; the reset state SHALL be FILL.
- REQ-015: data_ready_o SHALL be 1 only in FILL.
- REQ-016: In FILL, each accepted byte SHALL be written to buffer index byte_idx, then byte_idx increments.
- REQ-017: Each accepted byte SHALL increment msg_len (LEN_W bits). Overflow past 2^LEN_W-1 is unsupported.
- REQ-018: In FILL, accepting a byte at byte_idx=63 with data_last_i=0 SHALL cause FILL->ISSUE with last_block=0 and byte_idx cleared.
- REQ-019: On accepting a last byte at index k, define p=k+1.
- REQ-020: For p<=55, byte p SHALL be 0x80, bytes p+1..55 SHALL be 0, and bytes 56..63 SHALL hold {msg_len,3'b0} zero-extended to 64 bits; then ->ISSUE with last_block=1.
- REQ-021: For 56<=p<=63, byte p SHALL be 0x80, bytes p+1..63 SHALL be 0, and extra_pend SHALL be set with pad_done=1; then ->ISSUE with last_block=0.
- REQ-022: For p=64, the block SHALL be issued unmodified, and extra_pend SHALL be set with pad_done=0; then ->ISSUE with last_block=0.
- REQ-023: ISSUE SHALL last exactly one cycle: block_start_o=1, then ->WAIT.
- REQ-024: block_o, first_block_o and last_block_o SHALL be held stable from ISSUE until block_done_i is sampled in WAIT.
- REQ-025: In WAIT, on block_done_i, the next state SHALL be EXTRA if extra_pend is set.
- REQ-026: In WAIT, on block_done_i with last_block=1, msg_done_o SHALL pulse, msg_len, byte_idx and the buffer SHALL clear, first flag SHALL set, and the next state SHALL be FILL.
- REQ-027: In WAIT, on block_done_i otherwise, the buffer SHALL clear and the next state SHALL be FILL.
- REQ-028: EXTRA (one cycle) SHALL build the final block: byte 0 = pad_done ? 0x00 : 0x80, bytes 1..55 = 0, bytes 56..63 = length; it SHALL clear extra_pend, set last_block=1 and go ->ISSUE.
- REQ-029: first_block_o SHALL be 1 for the first issued block after reset or after msg_done_o, and 0 thereafter.
- REQ-030: Latency: block_start_o SHALL assert in the cycle after the block-completing byte is accepted (one cycle later again via EXTRA).
- REQ-031: block_done_i outside WAIT SHALL be ignored.
- REQ-032: data_valid_i outside FILL SHALL be ignored; no byte is consumed.
- REQ-033: data_last_i without data_valid_i SHALL be ignored.
- REQ-034: Zero-length messages are unsupported.

Reset
- REQ-035: While rstn_i=0: state=FILL, byte_idx=0, msg_len=0, buffer=0, extra_pend=0, first flag=1.
- REQ-036: While rstn_i=0, output reset values SHALL be: block_o=0, block_start_o=0, last_block_o=0, msg_done_o=0, first_block_o=1, data_ready_o=0.
- REQ-037: data_ready_o SHALL rise in the first cycle after deassertion.
- REQ-038: Reset asserted mid-message or in WAIT SHALL abort all progress; no block_start_o or msg_done_o SHALL follow until new input.

Verification
- REQ-039: "abc" (61,62,63, last on 63) -> one block_start_o; block_o=61626380_00..00_00000018; first=1, last=1; msg_done_o after block_done_i.
- REQ-040: 55 bytes 0x00 -> one block; byte 55=0x80; bytes 56..63=0x00000000000001B8; first=last=1.
- REQ-041: 56 bytes 0x00 -> block 1 has byte 56=0x80, first=1, last=0; block 2 is all zero except length 0x1C0, first=0, last=1.
- REQ-042: 64 bytes 0x41 -> block 1 is all 0x41, last=0; block 2 has byte 0=0x80 and length 0x200, last=1.
- REQ-043: Hold block_done_i low for 100 cycles -> data_ready_o=0 throughout, block_o stable, no bytes consumed; then a new message's first block has first_block_o=1.
- REQ-044: Assert rstn_i after 10 bytes, then send "abc" -> output is identical to the "abc" scenario.

Source files
------------

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects message bytes into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit-length, and hands
// each block to the compression core with start/first/last qualifiers.
module sha256_padder #(
    parameter int LEN_W = 32
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [7:0]   data_i,
    input  logic         data_valid_i,
    input  logic         data_last_i,
    output logic         data_ready_o,
    output logic [511:0] block_o,
    output logic         block_start_o,
    output logic         first_block_o,
    output logic         last_block_o,
    input  logic         block_done_i,
    output logic         msg_done_o
);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, EXTRA} state_t;

    state_t             state;
    // Byte 0 is the most significant byte so the buffer maps straight onto block_o.
    logic [0:63][7:0]   buffer;
    logic [5:0]         byte_idx;
    logic [LEN_W-1:0]   msg_len;
    logic               extra_pend;
    logic               pad_done;
    logic               first_q;
    logic               last_q;
    logic               ready_q;
    logic               start_q;
    logic               done_q;

    logic [LEN_W-1:0]   len_inc;
    logic [63:0]        len_bits_inc;
    logic [63:0]        len_bits;
    logic [6:0]         pos;
    logic [0:63][7:0]   fill_buf;
    logic [0:63][7:0]   extra_buf;

    assign len_inc      = msg_len + LEN_W'(1);
    assign len_bits_inc = 64'(len_inc) << 3;
    assign len_bits     = 64'(msg_len) << 3;
    // Position of the 0x80 marker if the byte being accepted is the last one.
    assign pos          = {1'b0, byte_idx} + 7'd1;

    // Buffer contents after accepting the current byte, including in-place padding.
    always_comb begin
        fill_buf           = buffer;
        fill_buf[byte_idx] = data_i;
        if (data_last_i) begin
            for (int i = 0; i < 64; i++) begin
                if (7'(i) == pos)
                    fill_buf[i] = 8'h80;
                else if (7'(i) > pos)
                    fill_buf[i] = 8'h00;
            end
            if (pos <= 7'd55) begin
                for (int i = 0; i < 8; i++)
                    fill_buf[56+i] = len_bits_inc[63-8*i -: 8];
            end
        end
    end

    // Trailing block used when the padding/length did not fit in the last data block.
    always_comb begin
        extra_buf    = '0;
        extra_buf[0] = pad_done ? 8'h00 : 8'h80;
        for (int i = 0; i < 8; i++)
            extra_buf[56+i] = len_bits[63-8*i -: 8];
    end

    // Control FSM with registered handshake and qualifier outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= FILL;
            buffer     <= '0;
            byte_idx   <= '0;
            msg_len    <= '0;
            extra_pend <= 1'b0;
            pad_done   <= 1'b0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            ready_q    <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                FILL: begin
                    ready_q <= 1'b1;
                    if (ready_q && data_valid_i) begin
                        buffer   <= fill_buf;
                        msg_len  <= len_inc;
                        byte_idx <= byte_idx + 6'd1;
                        if (data_last_i) begin
                            if (pos <= 7'd55) begin
                                last_q     <= 1'b1;
                                extra_pend <= 1'b0;
                            end else begin
                                // Marker (or nothing) fits, length does not: needs a trailing block.
                                last_q     <= 1'b0;
                                extra_pend <= 1'b1;
                                pad_done   <= (pos != 7'd64);
                            end
                            byte_idx <= '0;
                            ready_q  <= 1'b0;
                            start_q  <= 1'b1;
                            state    <= ISSUE;
                        end else if (byte_idx == 6'd63) begin
                            last_q  <= 1'b0;
                            ready_q <= 1'b0;
                            start_q <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (block_done_i) begin
                        buffer   <= '0;
                        byte_idx <= '0;
                        if (extra_pend) begin
                            first_q <= 1'b0;
                            state   <= EXTRA;
                        end else if (last_q) begin
                            done_q  <= 1'b1;
                            msg_len <= '0;
                            first_q <= 1'b1;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state   <= FILL;
                        end else begin
                            first_q <= 1'b0;
                            ready_q <= 1'b1;
                            state   <= FILL;
                        end
                    end
                end
                EXTRA: begin
                    buffer     <= extra_buf;
                    extra_pend <= 1'b0;
                    last_q     <= 1'b1;
                    start_q    <= 1'b1;
                    state      <= ISSUE;
                end
                default: state <= FILL;
            endcase
        end
    end

    assign data_ready_o  = ready_q;
    assign block_o       = buffer;
    assign block_start_o = start_q;
    assign first_block_o = first_q;
    assign last_block_o  = last_q;
    assign msg_done_o    = done_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known padded blocks for short, boundary
// and multi-block messages, stall behaviour and reset abort.
module tb_sha256_padder;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic [7:0]   data_i = '0;
    logic         data_valid_i = 1'b0;
    logic         data_last_i = 1'b0;
    logic         data_ready_o;
    logic [511:0] block_o;
    logic         block_start_o;
    logic         first_block_o;
    logic         last_block_o;
    logic         block_done_i = 1'b0;
    logic         msg_done_o;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [511:0] ABC_BLK  = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] Z55_BLK  = {440'h0, 8'h80, 64'h1B8};
    localparam logic [511:0] Z56_BLK1 = {448'h0, 8'h80, 56'h0};
    localparam logic [511:0] Z56_BLK2 = {448'h0, 64'h1C0};
    localparam logic [511:0] A64_BLK1 = {64{8'h41}};
    localparam logic [511:0] A64_BLK2 = {8'h80, 440'h0, 64'h200};

    sha256_padder #(.LEN_W(32)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .data_i        (data_i),
        .data_valid_i  (data_valid_i),
        .data_last_i   (data_last_i),
        .data_ready_o  (data_ready_o),
        .block_o       (block_o),
        .block_start_o (block_start_o),
        .first_block_o (first_block_o),
        .last_block_o  (last_block_o),
        .block_done_i  (block_done_i),
        .msg_done_o    (msg_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!data_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!data_ready_o) chk1("ready_timeout", data_ready_o, 1'b1);
        data_i       = b;
        data_valid_i = 1'b1;
        data_last_i  = last;
        @(posedge clk_i);
        #1;
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
    endtask

    // Returns number of negedges until block_start_o is seen (40 means timeout).
    task automatic wait_start(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!block_start_o && cyc < 40);
    endtask

    task automatic pulse_done();
        @(negedge clk_i);
        block_done_i = 1'b1;
        @(posedge clk_i);
        #1;
        block_done_i = 1'b0;
    endtask

    task automatic send_abc();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
    endtask

    task automatic check_abc_flow(input string tag);
        int cyc;
        wait_start(cyc);
        chki({tag, "_latency"}, cyc, 1);
        chkb({tag, "_block"}, block_o, ABC_BLK);
        chk1({tag, "_first"}, first_block_o, 1'b1);
        chk1({tag, "_last"}, last_block_o, 1'b1);
        @(negedge clk_i);
        chk1({tag, "_start_pulse"}, block_start_o, 1'b0);
        pulse_done();
        @(negedge clk_i);
        chk1({tag, "_msg_done"}, msg_done_o, 1'b1);
        chk1({tag, "_ready_after"}, data_ready_o, 1'b1);
        @(negedge clk_i);
        chk1({tag, "_msg_done_pulse"}, msg_done_o, 1'b0);
    endtask

    initial begin
        int  cyc;
        bit  ok;
        logic [511:0] snap;

        // Reset values
        #12;
        chkb("rst_block", block_o, '0);
        chk1("rst_start", block_start_o, 1'b0);
        chk1("rst_last", last_block_o, 1'b0);
        chk1("rst_done", msg_done_o, 1'b0);
        chk1("rst_first", first_block_o, 1'b1);
        chk1("rst_ready", data_ready_o, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk1("ready_after_rst", data_ready_o, 1'b1);

        // block_done and data_last without valid in FILL are ignored
        block_done_i = 1'b1;
        data_last_i  = 1'b1;
        @(negedge clk_i);
        block_done_i = 1'b0;
        data_last_i  = 1'b0;
        @(negedge clk_i);
        chk1("stray_done_msg", msg_done_o, 1'b0);
        chk1("stray_done_ready", data_ready_o, 1'b1);

        // "abc"
        send_abc();
        check_abc_flow("abc");

        // 55 zero bytes: padding fits in the one block
        for (int i = 0; i < 55; i++) send(8'h00, i == 54);
        wait_start(cyc);
        chki("z55_latency", cyc, 1);
        chkb("z55_block", block_o, Z55_BLK);
        chk1("z55_first", first_block_o, 1'b1);
        chk1("z55_last", last_block_o, 1'b1);
        pulse_done();
        @(negedge clk_i);
        chk1("z55_msg_done", msg_done_o, 1'b1);

        // 56 zero bytes: marker in block 1, length in block 2
        for (int i = 0; i < 56; i++) send(8'h00, i == 55);
        wait_start(cyc);
        chki("z56_latency1", cyc, 1);
        chkb("z56_block1", block_o, Z56_BLK1);
        chk1("z56_first1", first_block_o, 1'b1);
        chk1("z56_last1", last_block_o, 1'b0);
        chk1("z56_ready_issue", data_ready_o, 1'b0);
        pulse_done();
        wait_start(cyc);
        chki("z56_latency2", cyc, 2);
        chkb("z56_block2", block_o, Z56_BLK2);
        chk1("z56_first2", first_block_o, 1'b0);
        chk1("z56_last2", last_block_o, 1'b1);
        pulse_done();
        @(negedge clk_i);
        chk1("z56_msg_done", msg_done_o, 1'b1);

        // 64 bytes 0x41: full block, then marker + length block
        for (int i = 0; i < 64; i++) send(8'h41, i == 63);
        wait_start(cyc);
        chki("a64_latency1", cyc, 1);
        chkb("a64_block1", block_o, A64_BLK1);
        chk1("a64_first1", first_block_o, 1'b1);
        chk1("a64_last1", last_block_o, 1'b0);
        pulse_done();
        @(negedge clk_i);
        chk1("a64_no_early_done", msg_done_o, 1'b0);
        wait_start(cyc);
        chki("a64_latency2", cyc, 1);
        chkb("a64_block2", block_o, A64_BLK2);
        chk1("a64_last2", last_block_o, 1'b1);
        pulse_done();
        @(negedge clk_i);
        chk1("a64_msg_done", msg_done_o, 1'b1);

        // Stall: core holds off for 100 cycles while bytes are offered
        send_abc();
        wait_start(cyc);
        chki("stall_latency", cyc, 1);
        snap = block_o;
        ok = 1'b1;
        data_i       = 8'hFF;
        data_valid_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (data_ready_o !== 1'b0 || block_o !== snap || msg_done_o !== 1'b0) ok = 1'b0;
        end
        data_valid_i = 1'b0;
        chk1("stall_hold", ok, 1'b1);
        pulse_done();
        @(negedge clk_i);
        chk1("stall_msg_done", msg_done_o, 1'b1);
        send_abc();
        check_abc_flow("post_stall");

        // Reset mid-message, then "abc"
        for (int i = 0; i < 10; i++) send(8'h5A, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        chkb("midrst_block", block_o, '0);
        chk1("midrst_ready", data_ready_o, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        send_abc();
        check_abc_flow("after_midrst");

        // Reset while waiting on the core: nothing must follow
        send_abc();
        wait_start(cyc);
        chki("waitrst_latency", cyc, 1);
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        chk1("waitrst_first", first_block_o, 1'b1);
        chk1("waitrst_last", last_block_o, 1'b0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        ok = 1'b1;
        block_done_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (block_start_o !== 1'b0 || msg_done_o !== 1'b0) ok = 1'b0;
        end
        block_done_i = 1'b0;
        chk1("waitrst_quiet", ok, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
